// File: rtl/tt_um_reg_serializer.sv
// tt_um_reg_serializer
//
// Takes the 8-bit parallel output of the universal shift register on a
// valid/ready handshake and sends it out as an asynchronous serial frame:
// start bit (0), 8 data bits LSB first, optional even parity bit, stop bit (1).
// Every state, counter and output change is gated by the global enable, so
// the block runs in lock-step with the shift register.
//
// Parameters:
//   CLKS_PER_BIT - enabled clock cycles per serial bit (1..255)
//   PARITY_EN    - 1 inserts an even-parity bit after the data, 0 omits it
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous reset, active low
//   ena        - clock enable; when low everything is frozen
//   din        - parallel byte from the shift register
//   din_valid  - din is offered for transmission
//   din_ready  - a byte can be accepted this cycle
//   tx         - serial line, idles high, registered
//   busy       - a frame is in progress
//   frame_done - one-cycle pulse in the first cycle back in IDLE
module tt_um_reg_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic        par_q;
  logic        tx_q;
  logic        done_q;
  logic        bit_end;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Bit-time counter wraps to 0 on every bit boundary; with CLKS_PER_BIT=1
  // LAST_CNT is 0 so every enabled cycle is a boundary.
  assign bit_end = (cnt_q == LAST_CNT);
  assign cnt_d   = bit_end ? 8'd0 : cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // Cleared every clock regardless of ena so a pulse lasts exactly one clock.
      done_q <= 1'b0;
      if (ena) begin
        unique case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
            if (din_valid) begin
              shreg_q <= din;
              par_q   <= even_parity(din);
              cnt_q   <= 8'd0;
              idx_q   <= 3'd0;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end
          START: begin
            cnt_q <= cnt_d;
            if (bit_end) begin
              tx_q    <= shreg_q[0];
              state_q <= DATA;
            end
          end
          DATA: begin
            cnt_q <= cnt_d;
            if (bit_end) begin
              shreg_q <= {1'b0, shreg_q[7:1]};
              if (idx_q == 3'd7) begin
                idx_q <= 3'd0;
                if (PARITY_EN != 0) begin
                  tx_q    <= par_q;
                  state_q <= PARITY;
                end else begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
                end
              end else begin
                idx_q <= idx_q + 3'd1;
                // Next bit is the one about to land in shreg[0] after the shift.
                tx_q  <= shreg_q[1];
              end
            end
          end
          PARITY: begin
            cnt_q <= cnt_d;
            if (bit_end) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end
          STOP: begin
            cnt_q <= cnt_d;
            if (bit_end) begin
              tx_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign din_ready  = (state_q == IDLE) & ena;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tt_um_reg_serializer.sv
// Directed testbench for tt_um_reg_serializer. Three instances share clock,
// reset, enable and din: defaults (4 clocks/bit, parity), 1 clock/bit without
// parity, and 1 clock/bit with parity. Expected frames are hand-written bit
// strings in transmission order.
module tb_tt_um_reg_serializer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;

  logic dv_d, rdy_d, tx_d, busy_d, fd_d;
  logic dv_f, rdy_f, tx_f, busy_f, fd_f;
  logic dv_p, rdy_p, tx_p, busy_p, fd_p;

  int vectors = 0;
  int errors  = 0;

  tt_um_reg_serializer u_def (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(dv_d),
    .din_ready(rdy_d), .tx(tx_d), .busy(busy_d), .frame_done(fd_d)
  );

  tt_um_reg_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u_f (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(dv_f),
    .din_ready(rdy_f), .tx(tx_f), .busy(busy_f), .frame_done(fd_f)
  );

  tt_um_reg_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1)) u_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(dv_p),
    .din_ready(rdy_p), .tx(tx_p), .busy(busy_p), .frame_done(fd_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {tx, busy, frame_done, din_ready} of the selected instance
  function automatic logic [3:0] outs(input int sel);
    case (sel)
      0:       return {tx_d, busy_d, fd_d, rdy_d};
      1:       return {tx_f, busy_f, fd_f, rdy_f};
      default: return {tx_p, busy_p, fd_p, rdy_p};
    endcase
  endfunction

  task automatic set_dv(input int sel, input logic v);
    case (sel)
      0:       dv_d = v;
      1:       dv_f = v;
      default: dv_p = v;
    endcase
  endtask

  // Offer a byte and let one edge accept it; returns in the first frame cycle.
  task automatic send(input int sel, input logic [7:0] d, input bit hold, input string tag);
    logic [3:0] o;
    din = d;
    set_dv(sel, 1'b1);
    #1;
    o = outs(sel);
    chk({tag, "_ready_before_accept"}, o[0], 1'b1);
    tick();
    if (!hold) set_dv(sel, 1'b0);
  endtask

  // Walk a frame from its first cycle to the first idle cycle after it.
  // Optionally drops ena for off_len cycles starting at frame cycle off_s, and
  // optionally pulses din_valid (with a different din) at frame cycle pulse_c.
  task automatic check_frame(input int sel, input string pat, input int cpb,
                             input int off_s, input int off_len, input int pulse_c,
                             input string tag);
    int nb;
    int total;
    int dis;
    logic [3:0] o;
    logic exp_tx;
    nb    = pat.len();
    total = nb * cpb + off_len;
    dis   = 0;
    for (int c = 1; c <= total; c++) begin
      ena = !(off_len > 0 && c >= off_s && c < off_s + off_len);
      if (pulse_c > 0 && c == pulse_c) begin
        din = ~din;
        set_dv(sel, 1'b1);
      end
      if (pulse_c > 0 && c == pulse_c + 1) set_dv(sel, 1'b0);
      #1;
      o      = outs(sel);
      exp_tx = (pat.getc((c - 1 - dis) / cpb) == "1");
      chk($sformatf("%s_c%0d_tx", tag, c), o[3], exp_tx);
      chk($sformatf("%s_c%0d_busy", tag, c), o[2], 1'b1);
      chk($sformatf("%s_c%0d_done", tag, c), o[1], 1'b0);
      chk($sformatf("%s_c%0d_ready", tag, c), o[0], 1'b0);
      if (!ena) dis++;
      tick();
    end
    ena = 1'b1;
    #1;
    o = outs(sel);
    chk({tag, "_end_done"}, o[1], 1'b1);
    chk({tag, "_end_busy"}, o[2], 1'b0);
    chk({tag, "_end_tx"}, o[3], 1'b1);
    chk({tag, "_end_ready"}, o[0], 1'b1);
  endtask

  initial begin
    logic [3:0] o;
    rst_n = 1'b0;
    ena   = 1'b1;
    din   = 8'h00;
    dv_d  = 1'b0;
    dv_f  = 1'b0;
    dv_p  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_tx", tx_d, 1'b1);
    chk("rst_busy", busy_d, 1'b0);
    chk("rst_done", fd_d, 1'b0);
    chk("rst_ready", rdy_d, 1'b1);
    chk("rst_tx_fast", tx_f, 1'b1);
    ena = 1'b0;
    #1;
    chk("rst_ready_ena_low", rdy_d, 1'b0);
    ena = 1'b1;
    rst_n = 1'b1;
    tick();

    // Default frame 0xA5
    send(0, 8'hA5, 1'b0, "a5");
    check_frame(0, "01010010101", 4, 0, 0, 0, "a5");
    tick();
    chk("a5_done_one_clock", fd_d, 1'b0);
    chk("a5_idle_ready", rdy_d, 1'b1);

    // 1 clock/bit, no parity, 0x07
    send(1, 8'h07, 1'b0, "f07");
    check_frame(1, "0111000001", 1, 0, 0, 0, "f07");
    tick();

    // 1 clock/bit with parity, 0x07: parity bit is 1
    send(2, 8'h07, 1'b0, "p07");
    check_frame(2, "01110000011", 1, 0, 0, 0, "p07");
    tick();

    // ena low in idle: no accept
    ena  = 1'b0;
    dv_d = 1'b1;
    din  = 8'h55;
    #1;
    chk("enalow_ready", rdy_d, 1'b0);
    tick();
    tick();
    chk("enalow_busy", busy_d, 1'b0);
    chk("enalow_tx", tx_d, 1'b1);
    dv_d = 1'b0;
    ena  = 1'b1;
    tick();
    chk("enalow_busy_after", busy_d, 1'b0);

    // Back-to-back 0xFF then 0x00, din_valid held, din changed mid-frame
    send(0, 8'hFF, 1'b1, "ff");
    din = 8'h00;
    check_frame(0, "01111111101", 4, 0, 0, 0, "ff");
    tick();
    dv_d = 1'b0;
    check_frame(0, "00000000001", 4, 0, 0, 0, "b2b00");
    tick();

    // ena low for 5 cycles in the middle of data bit 3 of 0x96
    send(0, 8'h96, 1'b0, "ena");
    check_frame(0, "00110100101", 4, 19, 5, 0, "ena");
    tick();

    // Reset during the parity bit of 0x5A (parity 0)
    send(0, 8'h5A, 1'b0, "abort");
    repeat (37) tick();
    chk("abort_parity_tx", tx_d, 1'b0);
    chk("abort_parity_busy", busy_d, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_d, 1'b1);
    chk("abort_busy", busy_d, 1'b0);
    chk("abort_done", fd_d, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", i), fd_d, 1'b0);
      chk($sformatf("abort_idle_%0d", i), busy_d, 1'b0);
    end
    send(0, 8'h3C, 1'b0, "x3c");
    check_frame(0, "00011110001", 4, 0, 0, 0, "x3c");
    tick();

    // din_valid pulse while busy is ignored
    send(1, 8'h81, 1'b0, "ign");
    check_frame(1, "0100000011", 1, 0, 0, 4, "ign");
    for (int i = 0; i < 4; i++) begin
      tick();
      o = outs(1);
      chk($sformatf("ign_nodone_%0d", i), o[1], 1'b0);
      chk($sformatf("ign_idle_%0d", i), o[2], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
